// File: rtl/dadda_pkg.sv
// Shared helpers and payload types for the pipelined Dadda multiplier.
// Height sequence, layer count and the stage-1 operand bundle.
package dadda_pkg;

  localparam int MAX_W     = 32;
  localparam int MAX_TAG_W = 16;

  function automatic int dadda_height(int j);
    int d;
    d = 2;
    for (int k = 1; k < j; k++) d = (d * 3) / 2;
    return d;
  endfunction

  // Number of layers = count of heights strictly below the tallest column.
  function automatic int dadda_layers(int width);
    int n;
    n = 0;
    for (int j = 1; j <= 16; j++)
      if (dadda_height(j) < width) n = j;
    return n;
  endfunction

  function automatic int prod_w(int width);
    return 2 * width;
  endfunction

  typedef struct packed {
    logic [MAX_W-1:0]     a;
    logic [MAX_W-1:0]     b;
    logic                 sgn;
    logic [MAX_TAG_W-1:0] tag;
  } s1_t;

endpackage

// File: rtl/dadda_tree.sv
// Combinational partial-product matrix and Dadda reduction to two rows.
// Signed mode uses Baugh-Wooley bit inversion plus two constant ones.
module dadda_tree
  import dadda_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [2*WIDTH-1:0] sum_row,
  output logic [2*WIDTH-1:0] carry_row
);

  localparam int PW     = prod_w(WIDTH);
  localparam int MH     = WIDTH + 1;
  localparam int LAYERS = dadda_layers(WIDTH);

  logic m  [PW][MH];
  logic nm [PW][MH];
  int   h  [PW];
  int   nh [PW];
  int   d;
  int   idx;
  int   cnt;
  logic s;
  logic c;
  logic pp;

  always_comb begin
    m   = '{default: 1'b0};
    nm  = '{default: 1'b0};
    h   = '{default: 0};
    nh  = '{default: 0};
    d   = 0;
    idx = 0;
    cnt = 0;
    s   = 1'b0;
    c   = 1'b0;
    pp  = 1'b0;
    sum_row   = '0;
    carry_row = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = a[j] & b[i];
        if (sgn && ((i == WIDTH-1) != (j == WIDTH-1)))
          pp = ~pp;
        m[i+j][h[i+j]] = pp;
        h[i+j]++;
      end
    end
    m[WIDTH][h[WIDTH]] = sgn;
    h[WIDTH]++;
    m[PW-1][h[PW-1]] = sgn;
    h[PW-1]++;

    for (int l = LAYERS; l >= 1; l--) begin
      d  = dadda_height(l);
      nm = '{default: 1'b0};
      nh = '{default: 0};
      for (int i = 0; i < PW; i++) begin
        idx = 0;
        // Incoming carries already sit in nm[i] and count toward d.
        cnt = h[i] + nh[i];
        for (int k = 0; k < MH; k++) begin
          if (cnt > d) begin
            if (cnt == d + 1) begin
              s = m[i][idx] ^ m[i][idx+1];
              c = m[i][idx] & m[i][idx+1];
              idx += 2;
              cnt -= 1;
            end else begin
              s = m[i][idx] ^ m[i][idx+1] ^ m[i][idx+2];
              c = (m[i][idx] & m[i][idx+1])
                | (m[i][idx+2] & (m[i][idx] ^ m[i][idx+1]));
              idx += 3;
              cnt -= 2;
            end
            nm[i][nh[i]] = s;
            nh[i]++;
            if (i + 1 < PW) begin
              nm[i+1][nh[i+1]] = c;
              nh[i+1]++;
            end
          end
        end
        for (int r = 0; r < MH; r++) begin
          if (r >= idx && r < h[i]) begin
            nm[i][nh[i]] = m[i][r];
            nh[i]++;
          end
        end
      end
      m = nm;
      h = nh;
    end

    for (int i = 0; i < PW; i++) begin
      sum_row[i]   = m[i][0];
      carry_row[i] = m[i][1];
    end
  end

endmodule

// File: rtl/dadda_mult_pipe.sv
// Three-stage Dadda multiplier with valid/ready flow control.
// Stages: operand capture, tree reduction, carry-propagate add.
module dadda_mult_pipe
  import dadda_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = prod_w(WIDTH);

  if (WIDTH < 4 || WIDTH > MAX_W || TAG_W > MAX_TAG_W) begin : g_bad
    $error("dadda_mult_pipe: unsupported WIDTH/TAG_W");
  end

  logic          v1;
  logic          v2;
  logic          v3;
  logic          load2;
  logic          load3;
  s1_t           s1;
  logic [PW-1:0] sum_d;
  logic [PW-1:0] carry_d;
  logic [PW-1:0] sum_q;
  logic [PW-1:0] carry_q;
  logic [TAG_W-1:0] tag2;
  logic          unused_s1;

  assign load3     = !v3 || out_ready;
  assign load2     = !v2 || load3;
  assign in_ready  = !v1 || load2;
  assign out_valid = v3;
  assign unused_s1 = ^s1;

  dadda_tree #(.WIDTH(WIDTH)) u_tree (
    .a         (s1.a[WIDTH-1:0]),
    .b         (s1.b[WIDTH-1:0]),
    .sgn       (s1.sgn),
    .sum_row   (sum_d),
    .carry_row (carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      s1       <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      tag2     <= '0;
      out_prod <= '0;
      out_tag  <= '0;
    end else begin
      if (in_ready) begin
        v1 <= in_valid;
        if (in_valid)
          s1 <= '{a:   MAX_W'(in_a),
                  b:   MAX_W'(in_b),
                  sgn: in_signed,
                  tag: MAX_TAG_W'(in_tag)};
      end
      if (load2) begin
        v2 <= v1;
        if (v1) begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          tag2    <= s1.tag[TAG_W-1:0];
        end
      end
      // Carry out of the top column falls off: result is modulo 2^PW.
      if (load3) begin
        v3 <= v2;
        if (v2) begin
          out_prod <= sum_q + carry_q;
          out_tag  <= tag2;
        end
      end
    end
  end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Directed and swept checks for dadda_mult_pipe at WIDTH 8, 4 and 16.
// Expected products come from hand values and a longint reference.
module tb_dadda_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid, in_ready, in_signed;
  logic        out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_prod;

  logic        in_valid4, in_ready4, in_signed4;
  logic        out_valid4, out_ready4;
  logic [3:0]  in_a4, in_b4, in_tag4, out_tag4;
  logic [7:0]  out_prod4;

  logic        in_valid16, in_ready16, in_signed16;
  logic        out_valid16, out_ready16;
  logic [15:0] in_a16, in_b16;
  logic [3:0]  in_tag16, out_tag16;
  logic [31:0] out_prod16;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  t;
  } exp_t;

  int checks = 0;
  int passed = 0;

  dadda_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  dadda_mult_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4),
    .in_signed(in_signed4), .in_tag(in_tag4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_prod(out_prod4), .out_tag(out_tag4)
  );

  dadda_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16),
    .in_signed(in_signed16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_prod(out_prod16), .out_tag(out_tag16)
  );

  function automatic logic [31:0] refm(int w, logic [15:0] a,
                                       logic [15:0] b, logic s);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x -= (longint'(1) << w);
    if (s && b[w-1]) y -= (longint'(1) << w);
    p = x * y;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid);
    else passed++;
    checks++;
    if (out_prod !== 16'h0) $display("FAIL rst_prod got %h want 0", out_prod);
    else passed++;
    checks++;
    if (out_tag !== 4'h0) $display("FAIL rst_tag got %h want 0", out_tag);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_directed();
    logic [7:0]  ta [6];
    logic [7:0]  tb [6];
    logic        ts [6];
    logic [3:0]  tt [6];
    logic [15:0] te [6];
    ta = '{8'hFF, 8'h80, 8'hFF, 8'h7F, 8'h80, 8'h80};
    tb = '{8'hFF, 8'h80, 8'h02, 8'h81, 8'h7F, 8'h7F};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tt = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    te = '{16'hFE01, 16'h4000, 16'hFFFE, 16'hC0FF, 16'hC080, 16'h3F80};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = ta[i]; in_b = tb[i];
      in_signed = ts[i]; in_tag = tt[i];
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL dir_ready[%0d] got %b want 1", i, in_ready);
      else passed++;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL dir_lat1[%0d] got %b want 0", i, out_valid);
      else passed++;
      tick();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL dir_lat2[%0d] got %b want 0", i, out_valid);
      else passed++;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_prod !== te[i] || out_tag !== tt[i])
        $display("FAIL dir_res[%0d] got v=%b p=%h t=%h want v=1 p=%h t=%h",
                 i, out_valid, out_prod, out_tag, te[i], tt[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t q[$];
    int   nres, first, last;
    nres = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) begin
        in_a = 8'($urandom); in_b = 8'($urandom);
        in_signed = c[0]; in_tag = 4'(c);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.p = refm(8, 16'(in_a), 16'(in_b), in_signed);
        e.t = in_tag;
        q.push_back(e);
      end
      tick();
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL b2b_extra got p=%h want no result", out_prod);
        end else begin
          e = q.pop_front();
          if (out_prod !== e.p[15:0] || out_tag !== e.t)
            $display("FAIL b2b_res got p=%h t=%h want p=%h t=%h",
                     out_prod, out_tag, e.p[15:0], e.t);
          else passed++;
        end
        if (first < 0) first = c;
        last = c;
        nres++;
      end
    end
    checks++;
    if (nres !== 16) $display("FAIL b2b_count got %0d want 16", nres);
    else passed++;
    checks++;
    if (last - first !== 15) $display("FAIL b2b_gaps got span %0d want 15", last - first);
    else passed++;
  endtask

  task automatic test_backpressure();
    exp_t        e;
    exp_t        q[$];
    int          idx, n;
    logic [15:0] hold;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_a = 8'(idx * 37 + 3); in_b = 8'(idx * 11 + 250);
      in_signed = idx[0]; in_tag = 4'(8 + idx);
      in_valid = 1'b1;
      if (in_ready) begin
        e.p = refm(8, 16'(in_a), 16'(in_b), in_signed);
        e.t = in_tag;
        q.push_back(e);
        idx++;
      end
      tick();
    end
    checks++;
    if (idx !== 3) $display("FAIL bp_accepted got %0d want 3", idx);
    else passed++;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b1 || out_prod !== q[0].p[15:0])
      $display("FAIL bp_head got v=%b p=%h want v=1 p=%h", out_valid, out_prod, q[0].p[15:0]);
    else passed++;
    hold = out_prod;
    repeat (2) tick();
    checks++;
    if (out_prod !== hold || out_tag !== q[0].t)
      $display("FAIL bp_stable got p=%h t=%h want p=%h t=%h", out_prod, out_tag, hold, q[0].t);
    else passed++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL bp_dup got p=%h want no result", out_prod);
        end else begin
          e = q.pop_front();
          if (out_prod !== e.p[15:0] || out_tag !== e.t)
            $display("FAIL bp_drain got p=%h t=%h want p=%h t=%h",
                     out_prod, out_tag, e.p[15:0], e.t);
          else passed++;
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n !== 3) $display("FAIL bp_count got %0d want 3", n);
    else passed++;
  endtask

  task automatic test_bubble();
    exp_t e;
    exp_t q[$];
    int   n;
    out_ready = 1'b0;
    in_a = 8'hC3; in_b = 8'h5A; in_signed = 1'b1; in_tag = 4'hA;
    in_valid = 1'b1;
    e.p = refm(8, 16'(in_a), 16'(in_b), 1'b1); e.t = 4'hA;
    q.push_back(e);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL bub_ready0 got %b want 1", in_ready);
    else passed++;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    in_a = 8'h9C; in_b = 8'h3E; in_signed = 1'b0; in_tag = 4'hB;
    in_valid = 1'b1;
    e.p = refm(8, 16'(in_a), 16'(in_b), 1'b0); e.t = 4'hB;
    q.push_back(e);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL bub_ready1 got r=%b v=%b want r=1 v=1", in_ready, out_valid);
    else passed++;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_prod !== q[0].p[15:0])
      $display("FAIL bub_hold got p=%h want p=%h", out_prod, q[0].p[15:0]);
    else passed++;
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL bub_dup got p=%h want no result", out_prod);
        end else begin
          e = q.pop_front();
          if (out_prod !== e.p[15:0] || out_tag !== e.t)
            $display("FAIL bub_drain got p=%h t=%h want p=%h t=%h",
                     out_prod, out_tag, e.p[15:0], e.t);
          else passed++;
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n !== 2) $display("FAIL bub_count got %0d want 2", n);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(i + 7); in_b = 8'(i + 9);
      in_signed = 1'b0; in_tag = 4'(i + 1);
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL rm_fill[%0d] got %b want 1", i, in_ready);
      else passed++;
      tick();
    end
    rst = 1'b1;
    out_ready = 1'b1;
    in_a = 8'h11; in_b = 8'h22; in_tag = 4'hF;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_prod !== 16'h0 || out_tag !== 4'h0)
      $display("FAIL rm_clear got v=%b p=%h t=%h want v=0 p=0 t=0",
               out_valid, out_prod, out_tag);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", in_ready);
    else passed++;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL rm_stale got %0d results want 0", seen);
    else passed++;
  endtask

  task automatic test_sweep();
    exp_t e;
    exp_t q4[$];
    exp_t q16[$];
    int   n4, n16;
    n4 = 0; n16 = 0;
    out_ready4 = 1'b1;
    out_ready16 = 1'b1;
    for (int n = 0; n < 520; n++) begin
      in_valid4 = (n < 512);
      in_valid16 = (n < 512);
      in_a4 = n[3:0]; in_b4 = n[7:4];
      in_signed4 = n[8]; in_tag4 = n[3:0];
      in_a16 = 16'($urandom); in_b16 = 16'($urandom);
      in_signed16 = n[0]; in_tag16 = n[3:0];
      if (n == 0) begin in_a16 = 16'h8000; in_b16 = 16'h8000; in_signed16 = 1'b1; end
      if (n == 1) begin in_a16 = 16'hFFFF; in_b16 = 16'hFFFF; in_signed16 = 1'b0; end
      if (n == 2) begin in_a16 = 16'h7FFF; in_b16 = 16'h8000; in_signed16 = 1'b1; end
      if (in_valid4 && in_ready4) begin
        e.p = refm(4, 16'(in_a4), 16'(in_b4), in_signed4);
        e.t = in_tag4;
        q4.push_back(e);
      end
      if (in_valid16 && in_ready16) begin
        e.p = refm(16, in_a16, in_b16, in_signed16);
        e.t = in_tag16;
        q16.push_back(e);
      end
      tick();
      if (out_valid4) begin
        checks++;
        if (q4.size() == 0) begin
          $display("FAIL w4_extra got p=%h want no result", out_prod4);
        end else begin
          e = q4.pop_front();
          if (out_prod4 !== e.p[7:0] || out_tag4 !== e.t)
            $display("FAIL w4_res got p=%h t=%h want p=%h t=%h",
                     out_prod4, out_tag4, e.p[7:0], e.t);
          else passed++;
        end
        n4++;
      end
      if (out_valid16) begin
        checks++;
        if (q16.size() == 0) begin
          $display("FAIL w16_extra got p=%h want no result", out_prod16);
        end else begin
          e = q16.pop_front();
          if (out_prod16 !== e.p || out_tag16 !== e.t)
            $display("FAIL w16_res got p=%h t=%h want p=%h t=%h",
                     out_prod16, out_tag16, e.p, e.t);
          else passed++;
        end
        n16++;
      end
    end
    checks++;
    if (n4 !== 512) $display("FAIL w4_count got %0d want 512", n4);
    else passed++;
    checks++;
    if (n16 !== 512) $display("FAIL w16_count got %0d want 512", n16);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0;
    in_signed4 = 1'b0; in_tag4 = '0; out_ready4 = 1'b1;
    in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0;
    in_signed16 = 1'b0; in_tag16 = '0; out_ready16 = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
